// File: rtl/mem_access_if.sv
// Data-bus bundle between the mem_access stage (master) and the memory/bus fabric (slave).
// Single outstanding request, req held until a one-cycle ack.
interface mem_access_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [3:0]            bus_be_o;
  logic [31:0]           bus_wdata_o;
  logic                  bus_ack_i;
  logic [31:0]           bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: byte-lane alignment, load extension, bus timeout, WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise bus_err_o instead of being masked.
//
// state | meaning
// IDLE  | pass execute results to WB, accept a new load/store
// BUS   | request held on the bus, waiting for ack or timeout
module mem_access #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_mem_enable_i,
  input  logic [31:0] r_mem_addr_i,
  input  logic        w_mem_enable_i,
  input  logic [31:0] w_mem_addr_i,
  input  logic [31:0] w_mem_data_i,
  input  logic [2:0]  data_type_i,
  input  logic        ex_w_reg_enable_i,
  input  logic        mem_w_reg_enable_i,
  input  logic [4:0]  w_reg_addr_i,
  input  logic [31:0] ex_w_reg_data_i,
  mem_access_if.master bus,
  output logic        stall_o,
  output logic        wb_reg_enable_o,
  output logic [4:0]  wb_reg_addr_o,
  output logic [31:0] wb_reg_data_o,
  output logic        bus_err_o
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            type_q, type_d;
  logic [4:0]            rd_q, rd_d;
  logic                  ld_wen_q, ld_wen_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  wb_en_q, wb_en_d;
  logic [4:0]            wb_addr_q, wb_addr_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic                  err_q, err_d;

  logic                  req_en, is_byte, is_half;
  logic [31:0]           req_addr_raw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_be;
  logic [31:0]           req_wdata;
  logic [31:0]           rd_shifted, ld_data;

  // Request decode; unlisted type codes (incl. 000) behave as word.
  always_comb begin
    req_en       = w_mem_enable_i | r_mem_enable_i;
    req_addr_raw = w_mem_enable_i ? w_mem_addr_i : r_mem_addr_i;
    is_byte      = (data_type_i == 3'b001) || (data_type_i == 3'b101);
    is_half      = (data_type_i == 3'b010) || (data_type_i == 3'b110);
    req_addr     = req_addr_raw[ADDR_WIDTH-1:0];
    if (is_half) begin
      req_addr[0] = 1'b0;
    end else if (!is_byte) begin
      req_addr[1:0] = 2'b00;
    end
    if (is_byte) begin
      req_be    = 4'b0001 << req_addr[1:0];
      req_wdata = {4{w_mem_data_i[7:0]}};
    end else if (is_half) begin
      req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      req_wdata = {2{w_mem_data_i[15:0]}};
    end else begin
      req_be    = 4'b1111;
      req_wdata = w_mem_data_i;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = is_half ? req_addr_raw[0] : (!is_byte && (req_addr_raw[1:0] != 2'b00));
`endif

  always_comb begin
    rd_shifted = bus.bus_rdata_i >> {addr_q[1:0], 3'b000};
    case (type_q)
      3'b001:  ld_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b101:  ld_data = {24'h0, rd_shifted[7:0]};
      3'b010:  ld_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b110:  ld_data = {16'h0, rd_shifted[15:0]};
      default: ld_data = rd_shifted;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    type_d    = type_q;
    rd_d      = rd_q;
    ld_wen_d  = ld_wen_q;
    timer_d   = timer_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    err_d     = 1'b0;
    stall_o   = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (req_en) begin
`ifdef MEM_MISALIGN_TRAP_EN
          if (misalign) begin
            err_d = 1'b1;
          end else begin
            stall_o  = 1'b1;
            state_d  = BUS;
            addr_d   = req_addr;
            we_d     = w_mem_enable_i;
            be_d     = req_be;
            wdata_d  = req_wdata;
            type_d   = data_type_i;
            rd_d     = w_reg_addr_i;
            ld_wen_d = mem_w_reg_enable_i;
          end
`else
          stall_o  = 1'b1;
          state_d  = BUS;
          addr_d   = req_addr;
          we_d     = w_mem_enable_i;
          be_d     = req_be;
          wdata_d  = req_wdata;
          type_d   = data_type_i;
          rd_d     = w_reg_addr_i;
          ld_wen_d = mem_w_reg_enable_i;
`endif
        end else begin
          wb_en_d   = ex_w_reg_enable_i && (w_reg_addr_i != 5'd0);
          wb_addr_d = w_reg_addr_i;
          wb_data_d = ex_w_reg_data_i;
        end
      end
      BUS: begin
        if (bus.bus_ack_i) begin
          state_d   = IDLE;
          timer_d   = '0;
          wb_en_d   = !we_q && ld_wen_q && (rd_q != 5'd0);
          wb_addr_d = rd_q;
          wb_data_d = ld_data;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TO_LAST)) begin
          // Abandon the access; upstream is released in this same cycle.
          state_d = IDLE;
          timer_d = '0;
          err_d   = 1'b1;
        end else begin
          stall_o = 1'b1;
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      type_q    <= '0;
      rd_q      <= '0;
      ld_wen_q  <= 1'b0;
      timer_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      type_q    <= type_d;
      rd_q      <= rd_d;
      ld_wen_q  <= ld_wen_d;
      timer_q   <= timer_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign bus.bus_req_o   = (state_q == BUS);
  assign bus.bus_we_o    = (state_q == BUS) && we_q;
  assign bus.bus_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.bus_be_o    = be_q;
  assign bus.bus_wdata_o = wdata_q;
  assign wb_reg_enable_o = wb_en_q;
  assign wb_reg_addr_o   = wb_addr_q;
  assign wb_reg_data_o   = wb_data_q;
  assign bus_err_o       = err_q;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected bus/writeback/error events,
// an independent monitor pops and compares them as the DUT presents them.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_mem_enable_i, w_mem_enable_i, ex_w_reg_enable_i, mem_w_reg_enable_i;
  logic [31:0] r_mem_addr_i, w_mem_addr_i, w_mem_data_i, ex_w_reg_data_i;
  logic [2:0]  data_type_i;
  logic [4:0]  w_reg_addr_i;
  logic        stall_o, wb_reg_enable_o, bus_err_o;
  logic [4:0]  wb_reg_addr_o;
  logic [31:0] wb_reg_data_o;

  always #5 clk = ~clk;

  mem_access_if #(.ADDR_WIDTH(32)) bif ();

  mem_access #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .r_mem_enable_i(r_mem_enable_i), .r_mem_addr_i(r_mem_addr_i),
    .w_mem_enable_i(w_mem_enable_i), .w_mem_addr_i(w_mem_addr_i), .w_mem_data_i(w_mem_data_i),
    .data_type_i(data_type_i), .ex_w_reg_enable_i(ex_w_reg_enable_i),
    .mem_w_reg_enable_i(mem_w_reg_enable_i), .w_reg_addr_i(w_reg_addr_i),
    .ex_w_reg_data_i(ex_w_reg_data_i), .bus(bif), .stall_o(stall_o),
    .wb_reg_enable_o(wb_reg_enable_o), .wb_reg_addr_o(wb_reg_addr_o),
    .wb_reg_data_o(wb_reg_data_o), .bus_err_o(bus_err_o)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} bus_t;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   err_exp = 0;
  int   total = 0;
  int   bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void evt_fail(string name);
    total++;
    bad++;
    $display("FAIL %s: event seen with nothing expected", name);
  endfunction

  function automatic void push_bus(logic we, logic [31:0] addr, logic [3:0] be, logic [31:0] wd);
    bus_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wd;
    bus_q.push_back(e);
  endfunction

  function automatic void push_wb(logic [4:0] rd, logic [31:0] data);
    wb_t e;
    e.rd = rd; e.data = data;
    wb_q.push_back(e);
  endfunction

  initial begin : monitor
    logic prev_req;
    bus_t eb;
    wb_t  ew;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.bus_req_o && !prev_req) begin
        if (bus_q.size() == 0) evt_fail("bus_req");
        else begin
          eb = bus_q.pop_front();
          chk("bus_we", 32'(bif.bus_we_o), 32'(eb.we));
          chk("bus_addr", bif.bus_addr_o, eb.addr);
          chk("bus_be", 32'(bif.bus_be_o), 32'(eb.be));
          chk("bus_wdata", bif.bus_wdata_o, eb.wdata);
        end
      end
      prev_req = bif.bus_req_o;
      if (wb_reg_enable_o) begin
        if (wb_q.size() == 0) evt_fail("wb");
        else begin
          ew = wb_q.pop_front();
          chk("wb_rd", 32'(wb_reg_addr_o), 32'(ew.rd));
          chk("wb_data", wb_reg_data_o, ew.data);
        end
      end
      if (bus_err_o) begin
        if (err_exp == 0) evt_fail("bus_err");
        else begin
          err_exp--;
          chk("err_req_low", 32'(bif.bus_req_o), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_in();
    r_mem_enable_i = 0; r_mem_addr_i = 0; w_mem_enable_i = 0; w_mem_addr_i = 0;
    w_mem_data_i = 0; data_type_i = 0; ex_w_reg_enable_i = 0; mem_w_reg_enable_i = 0;
    w_reg_addr_i = 0; ex_w_reg_data_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the IDLE request cycle; ack arrives in BUS cycle waits+1.
  task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] dt, input logic [4:0] rd, input logic mwen,
                        input int waits, input logic [31:0] rdata, input int exp_stall,
                        input string name);
    int stalls;
    stalls = 0;
    if (we) begin
      w_mem_enable_i = 1; w_mem_addr_i = addr; w_mem_data_i = wd;
    end else begin
      r_mem_enable_i = 1; r_mem_addr_i = addr;
    end
    data_type_i = dt; w_reg_addr_i = rd; mem_w_reg_enable_i = mwen;
    for (int c = 0; c <= waits + 1; c++) begin
      bif.bus_ack_i   = (c == waits + 1);
      bif.bus_rdata_i = (c == waits + 1) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (stall_o) stalls++;
      tick();
    end
    bif.bus_ack_i = 0;
    clear_in();
    chk({name, "_stall"}, 32'(stalls), 32'(exp_stall));
  endtask

  initial begin : stim
    int stalls;
    clear_in();
    bif.bus_ack_i = 0;
    bif.bus_rdata_i = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_req", 32'(bif.bus_req_o), 32'd0);
    chk("rst_we", 32'(bif.bus_we_o), 32'd0);
    chk("rst_addr", bif.bus_addr_o, 32'd0);
    chk("rst_be", 32'(bif.bus_be_o), 32'd0);
    chk("rst_wb_en", 32'(wb_reg_enable_o), 32'd0);
    chk("rst_wb_data", wb_reg_data_o, 32'd0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    tick();
    rst_n = 1;
    tick();

    // ALU pass-through, then rd=0 suppression
    ex_w_reg_enable_i = 1; w_reg_addr_i = 5; ex_w_reg_data_i = 32'h1234;
    push_wb(5, 32'h1234);
    @(negedge clk);
    chk("alu_stall", 32'(stall_o), 32'd0);
    tick();
    w_reg_addr_i = 0; ex_w_reg_data_i = 32'h999;
    tick();
    clear_in();
    tick();

    push_bus(0, 32'h1000, 4'b1000, 32'h0);
    push_wb(3, 32'hFFFF_FF80);
    mem_op(0, 32'h1003, 0, 3'b001, 3, 1, 3, 32'h80AA_BBCC, 4, "lb");

    push_bus(1, 32'h2000, 4'b1100, 32'hBEEF_BEEF);
    mem_op(1, 32'h2002, 32'h0000_BEEF, 3'b010, 0, 0, 1, 0, 2, "sh");

    push_bus(0, 32'h10, 4'b1111, 32'h0);
    push_wb(4, 32'hCAFE_F00D);
    mem_op(0, 32'h10, 0, 3'b011, 4, 1, 0, 32'hCAFE_F00D, 1, "lw0");
    push_bus(0, 32'h14, 4'b1111, 32'h0);
    push_wb(6, 32'h0102_0304);
    mem_op(0, 32'h14, 0, 3'b011, 6, 1, 0, 32'h0102_0304, 1, "lw1");

    push_bus(0, 32'h20, 4'b1100, 32'h0);
    push_wb(8, 32'hFFFF_8001);
    mem_op(0, 32'h22, 0, 3'b010, 8, 1, 0, 32'h8001_7FFF, 1, "lh");
    push_bus(0, 32'h20, 4'b1100, 32'h0);
    push_wb(9, 32'h0000_8001);
    mem_op(0, 32'h22, 0, 3'b110, 9, 1, 2, 32'h8001_7FFF, 3, "lhu");
    push_bus(0, 32'h40, 4'b0010, 32'h0);
    push_wb(10, 32'h0000_00F2);
    mem_op(0, 32'h41, 0, 3'b101, 10, 1, 0, 32'h0000_F200, 1, "lbu");
    push_bus(0, 32'h40, 4'b0100, 32'h0);
    push_wb(11, 32'h0000_007F);
    mem_op(0, 32'h42, 0, 3'b001, 11, 1, 0, 32'h007F_0000, 1, "lb_pos");
    push_bus(1, 32'h50, 4'b0010, 32'hA5A5_A5A5);
    mem_op(1, 32'h51, 32'h1234_56A5, 3'b001, 0, 0, 0, 0, 1, "sb");

    // type 000 acts as word; load to rd=0 writes nothing
    push_bus(0, 32'h60, 4'b1111, 32'h0);
    push_wb(12, 32'h89AB_CDEF);
    mem_op(0, 32'h60, 0, 3'b000, 12, 1, 0, 32'h89AB_CDEF, 1, "ldef");
    push_bus(0, 32'h70, 4'b1111, 32'h0);
    mem_op(0, 32'h70, 0, 3'b011, 0, 1, 0, 32'h7777_7777, 1, "lw_rd0");

    // store wins over a simultaneous load
    r_mem_enable_i = 1; r_mem_addr_i = 32'h80;
    push_bus(1, 32'h74, 4'b1111, 32'h1234_5678);
    mem_op(1, 32'h74, 32'h1234_5678, 3'b011, 0, 0, 0, 0, 1, "prio");

    // timeout: 16 BUS cycles without ack, then a stray ack in IDLE
    push_bus(0, 32'h100, 4'b1111, 32'h0);
    err_exp++;
    r_mem_enable_i = 1; r_mem_addr_i = 32'h100; data_type_i = 3'b011;
    w_reg_addr_i = 9; mem_w_reg_enable_i = 1;
    stalls = 0;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      tick();
    end
    clear_in();
    chk("to_stall", 32'(stalls), 32'd16);
    @(negedge clk);
    chk("to_req_drop", 32'(bif.bus_req_o), 32'd0);
    chk("to_err", 32'(bus_err_o), 32'd1);
    chk("to_wb_en", 32'(wb_reg_enable_o), 32'd0);
    tick();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h5555_5555;
    tick();
    bif.bus_ack_i = 0;
    repeat (2) tick();

`ifdef MEM_MISALIGN_TRAP_EN
    err_exp++;
    r_mem_enable_i = 1; r_mem_addr_i = 32'h3002; data_type_i = 3'b011;
    w_reg_addr_i = 7; mem_w_reg_enable_i = 1;
    @(negedge clk);
    chk("mis_stall", 32'(stall_o), 32'd0);
    tick();
    clear_in();
    repeat (2) tick();
`else
    push_bus(0, 32'h3000, 4'b1111, 32'h0);
    push_wb(7, 32'h1122_3344);
    mem_op(0, 32'h3002, 0, 3'b011, 7, 1, 0, 32'h1122_3344, 1, "lw_mis");
`endif

    // reset in the middle of an access, then a late ack
    push_bus(0, 32'h90, 4'b1111, 32'h0);
    r_mem_enable_i = 1; r_mem_addr_i = 32'h90; data_type_i = 3'b011;
    w_reg_addr_i = 14; mem_w_reg_enable_i = 1;
    tick();
    @(negedge clk);
    chk("mid_req", 32'(bif.bus_req_o), 32'd1);
    tick();
    rst_n = 0;
    clear_in();
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("mid_req_drop", 32'(bif.bus_req_o), 32'd0);
    tick();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h6666_6666;
    tick();
    bif.bus_ack_i = 0;
    repeat (3) tick();

    chk("bus_q_left", 32'(bus_q.size()), 32'd0);
    chk("wb_q_left", 32'(wb_q.size()), 32'd0);
    chk("err_left", 32'(err_exp), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
